// File: rtl/lmdpl_seq_ctrl.sv
// rtl/lmdpl_seq_ctrl.sv - LMDPL masked-gate sequencer: random fetch, mask load, optional precharge, evaluate, capture
// Optional precharge phase: define LMDPL_SEQ_PRECHARGE_EN to insert PRE between LOAD and EVAL.
module lmdpl_seq_ctrl #(
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic rnd_req_o,
  input  logic rnd_ack_i,
  output logic mask_load_o,
  output logic rail_en_o,
  input  logic x2_i,
  input  logic x2_bar_i,
  output logic out_capture_o,
  output logic done_o,
  input  logic err_clr_i,
  output logic err_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RND  = 3'd1,
    ST_LOAD = 3'd2,
    ST_PRE  = 3'd3,
    ST_EVAL = 3'd4,
    ST_CAPT = 3'd5
  } state_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] PRE_LOAD  = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYCLES - 1);

  state_t     state;
  state_t     nxt_state;
  logic [3:0] cnt;
  logic [3:0] nxt_cnt;

  // Next-state and phase-counter decode; the registered outputs below follow the next state.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start_i) nxt_state = ST_RND;
      end
      ST_RND: begin
        if (rnd_ack_i) nxt_state = ST_LOAD;
      end
      ST_LOAD: begin
`ifdef LMDPL_SEQ_PRECHARGE_EN
        nxt_state = ST_PRE;
        nxt_cnt   = PRE_LOAD;
`else
        nxt_state = ST_EVAL;
        nxt_cnt   = EVAL_LOAD;
`endif
      end
      ST_PRE: begin
        // Unreachable when precharge is disabled, since LOAD never enters PRE.
        if (cnt == 4'd0) begin
          nxt_state = ST_EVAL;
          nxt_cnt   = EVAL_LOAD;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      ST_EVAL: begin
        if (cnt == 4'd0) begin
          nxt_state = ST_CAPT;
          nxt_cnt   = 4'd0;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      ST_CAPT: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = 4'd0;
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = 4'd0;
      end
    endcase
  end

  // State register with Moore outputs registered from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      busy_o        <= 1'b0;
      rnd_req_o     <= 1'b0;
      mask_load_o   <= 1'b0;
      rail_en_o     <= 1'b0;
      out_capture_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      busy_o        <= (nxt_state != ST_IDLE);
      rnd_req_o     <= (nxt_state == ST_RND);
      mask_load_o   <= (nxt_state == ST_LOAD);
      rail_en_o     <= (nxt_state == ST_EVAL) || (nxt_state == ST_CAPT);
      out_capture_o <= (nxt_state == ST_CAPT);
      done_o        <= (nxt_state == ST_CAPT);
    end
  end

  // Sticky fault flag: equal rails at capture mean the dual-rail encoding broke; a new fault beats a clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else if ((state == ST_CAPT) && (x2_i == x2_bar_i)) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end

endmodule

// File: doc/lmdpl_seq_ctrl.md
LMDPL_SEQ_CTRL -- requirements
Module: lmdpl_seq_ctrl

Interface
REQ-001 The block SHALL have parameter PRE_CYCLES, default 1, precharge-phase length in clock cycles (legal range 1..15).
REQ-002 The block SHALL have parameter EVAL_CYCLES, default 2, evaluate-phase length in clock cycles (legal range 1..15).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset; ports follow.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 start_i  input  1  operation request, sampled only in IDLE.
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 rnd_req_o  output  1  request for fresh mask bit r.
REQ-009 rnd_ack_i  input  1  r valid and stable from this cycle on.
REQ-010 mask_load_o  output  1  enable for the mask-table register capture.
REQ-011 rail_en_o  output  1  dual-rail gate: 0 forces all second-stage rails (a2, a2_bar, b2, b2_bar) to 0 (precharge); 1 passes them.
REQ-012 x2_i, x2_bar_i  input  1 each  dual-rail gadget result.
REQ-013 out_capture_o  output  1  enable for capturing x2/x2_bar downstream.
REQ-014 done_o  output  1  single-cycle completion pulse.
REQ-015 err_clr_i  input  1  clears err_o.
REQ-016 err_o  output  1  sticky dual-rail fault flag.

Function
REQ-017 The FSM SHALL have states IDLE, RND, LOAD, PRE, EVAL, CAPT, and all outputs SHALL be registered Moore outputs decoded from the state.
REQ-018 In IDLE, start_i=1 SHALL move the FSM to RND; start_i=0 SHALL keep it in IDLE.
REQ-019 In RND, rnd_req_o SHALL be 1; the FSM SHALL stay in RND until rnd_ack_i=1, then move to LOAD.
REQ-020 LOAD SHALL last exactly 1 cycle with mask_load_o=1, then move to PRE (macro defined) or EVAL (macro undefined).
REQ-021 PRE SHALL last PRE_CYCLES cycles with rail_en_o=0, then move to EVAL.
REQ-022 EVAL SHALL last EVAL_CYCLES cycles with rail_en_o=1, then move to CAPT.
REQ-023 CAPT SHALL last 1 cycle with rail_en_o=1, out_capture_o=1 and done_o=1, then move to IDLE.
REQ-024 rail_en_o SHALL be 0 in IDLE, RND, LOAD and PRE.
REQ-025 A 4-bit down-counter SHALL time PRE and EVAL: load N-1 on state entry, exit the state when the count is 0.
REQ-026 start_i SHALL be ignored while busy_o=1; no request SHALL be queued.
REQ-027 Latency from start_i sampled high to done_o, with rnd_ack_i already high, SHALL be 3+EVAL_CYCLES cycles (macro undefined) or 3+PRE_CYCLES+EVAL_CYCLES cycles (macro defined).
REQ-028 In CAPT, x2_i==x2_bar_i SHALL set err_o to 1 on the next edge.
REQ-029 err_o SHALL remain 1 until err_clr_i=1; if set and clear coincide, set SHALL win.

Reset
REQ-030 rst=0 at a rising edge SHALL force state IDLE, counter 0 and err_o 0; every other output SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done_o and rail_en_o=0 from the next cycle.

Configuration
REQ-032 With macro LMDPL_SEQ_PRECHARGE_EN defined, the PRE state SHALL exist and be entered after LOAD.
REQ-033 With LMDPL_SEQ_PRECHARGE_EN undefined, the PRE state and PRE_CYCLES SHALL have no effect, and LOAD SHALL go directly to EVAL.

Verification
REQ-034 Macro undefined, EVAL_CYCLES=2, rnd_ack_i=1, start pulse at cycle 0 -> mask_load_o=1 at cycle 2, rail_en_o=1 at cycles 3-5, done_o=1 at cycle 5 only.
REQ-035 Macro defined, PRE_CYCLES=3, EVAL_CYCLES=2 -> rail_en_o=0 at cycles 3-5, done_o at cycle 8.
REQ-036 rnd_ack_i held 0 for 10 cycles after start -> rnd_req_o=1 and no mask_load_o for those 10 cycles; LOAD in the cycle after ack.
REQ-037 x2_i=x2_bar_i=1 in CAPT -> err_o=1 and held; err_clr_i pulse -> 0; clear coinciding with a new fault -> err_o stays 1.
REQ-038 rst=0 during EVAL -> next cycle busy_o=0, rail_en_o=0, no done_o; start_i pulsed during EVAL -> ignored, one done_o only.
